// File: rtl/match_scoreboard_if.sv
// Playfield/display bundle for the tug-of-war match scoreboard.
// master drives the playfield side, slave is the scoreboard.
interface match_scoreboard_if;
  logic       lmost;
  logic       rmost;
  logic       L;
  logic       R;
  logic       new_match;
  logic       round_reset;
  logic       point_p1;
  logic       point_p2;
  logic [1:0] winner;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;
  logic [6:0] hex_win;

  modport master (
    output lmost, rmost, L, R, new_match,
    input  round_reset, point_p1, point_p2, winner, hex_p1, hex_p2, hex_win
  );

  modport slave (
    input  lmost, rmost, L, R, new_match,
    output round_reset, point_p1, point_p2, winner, hex_p1, hex_p2, hex_win
  );
endinterface

// File: rtl/match_scoreboard.sv
// Multi-point tug-of-war match controller: scores, round restart and winner display.
// Optional post-point blinking hold is built when MATCH_HOLD_EN is defined.
module match_scoreboard #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  match_scoreboard_if.slave bus
);

  localparam logic [6:0] BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_0  = 7'b1000000;
  localparam logic [6:0] SEG_1  = 7'b1111001;
  localparam logic [6:0] SEG_2  = 7'b0100100;
  localparam logic [3:0] WIN_M1 = 4'(WIN_SCORE - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 9 || HOLD_CYCLES < 1) begin : g_param_check
    $error("match_scoreboard: WIN_SCORE or HOLD_CYCLES out of range");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

`ifdef MATCH_HOLD_EN
  typedef enum logic [1:0] {PLAY = 2'd0, HOLD = 2'd1, OVER = 2'd2} state_t;

  localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] hold_cnt, hold_cnt_d;
  logic          hold_p2, hold_p2_d;  // owner of the blinking digit
`else
  typedef enum logic [1:0] {PLAY = 2'd0, OVER = 2'd2} state_t;
`endif

  state_t     state, state_d;
  logic [3:0] score1, score2, score1_d, score2_d;
  logic [1:0] winner_d;
  logic [6:0] hex1_d, hex2_d, hexw_d;
  logic       rr_d, pp1_d, pp2_d;
  logic       blank1, blank2;
  logic       p1pt, p2pt, win1, win2;

  assign p1pt = bus.R & ~bus.L & bus.rmost & ~bus.lmost;
  assign p2pt = bus.L & ~bus.R & bus.lmost & ~bus.rmost;
  assign win1 = (score1 == WIN_M1);
  assign win2 = (score2 == WIN_M1);

  always_ff @(posedge clk) begin
    if (!reset) state <= PLAY;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      PLAY: begin
        if ((p1pt && win1) || (p2pt && win2)) state_d = OVER;
`ifdef MATCH_HOLD_EN
        else if (p1pt || p2pt)                state_d = HOLD;
`endif
      end
`ifdef MATCH_HOLD_EN
      HOLD:    if (hold_cnt == '0) state_d = PLAY;
`endif
      OVER:    if (bus.new_match) state_d = PLAY;
      default: state_d = PLAY;
    endcase
  end

  always_comb begin
    score1_d = score1;
    score2_d = score2;
    winner_d = bus.winner;
    hexw_d   = bus.hex_win;
    rr_d     = 1'b0;
    pp1_d    = 1'b0;
    pp2_d    = 1'b0;
    blank1   = 1'b0;
    blank2   = 1'b0;
`ifdef MATCH_HOLD_EN
    hold_cnt_d = hold_cnt;
    hold_p2_d  = hold_p2;
`endif
    case (state)
      PLAY: begin
        if (p1pt) begin
          score1_d = score1 + 4'd1;
          pp1_d    = 1'b1;
          if (win1) begin
            winner_d = 2'b01;
            hexw_d   = SEG_1;
          end else begin
`ifdef MATCH_HOLD_EN
            hold_cnt_d = HOLD_LOAD;
            hold_p2_d  = 1'b0;
`else
            rr_d = 1'b1;
`endif
          end
        end else if (p2pt) begin
          score2_d = score2 + 4'd1;
          pp2_d    = 1'b1;
          if (win2) begin
            winner_d = 2'b10;
            hexw_d   = SEG_2;
          end else begin
`ifdef MATCH_HOLD_EN
            hold_cnt_d = HOLD_LOAD;
            hold_p2_d  = 1'b1;
`else
            rr_d = 1'b1;
`endif
          end
        end
      end
`ifdef MATCH_HOLD_EN
      HOLD: begin
        if (hold_cnt == '0) begin
          rr_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt - CW'(1);
          // digit is shown whenever bit 0 matches its value at the scoring edge
          if (hold_cnt_d[0] != HOLD_LOAD[0]) begin
            blank1 = ~hold_p2;
            blank2 = hold_p2;
          end
        end
      end
`endif
      OVER: begin
        if (bus.new_match) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'b00;
          hexw_d   = BLANK;
          rr_d     = 1'b1;
        end
      end
      default: ;
    endcase
    hex1_d = blank1 ? BLANK : seg7(score1_d);
    hex2_d = blank2 ? BLANK : seg7(score2_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      score1          <= '0;
      score2          <= '0;
      bus.winner      <= 2'b00;
      bus.round_reset <= 1'b0;
      bus.point_p1    <= 1'b0;
      bus.point_p2    <= 1'b0;
      bus.hex_p1      <= SEG_0;
      bus.hex_p2      <= SEG_0;
      bus.hex_win     <= BLANK;
`ifdef MATCH_HOLD_EN
      hold_cnt        <= '0;
      hold_p2         <= 1'b0;
`endif
    end else begin
      score1          <= score1_d;
      score2          <= score2_d;
      bus.winner      <= winner_d;
      bus.round_reset <= rr_d;
      bus.point_p1    <= pp1_d;
      bus.point_p2    <= pp2_d;
      bus.hex_p1      <= hex1_d;
      bus.hex_p2      <= hex2_d;
      bus.hex_win     <= hexw_d;
`ifdef MATCH_HOLD_EN
      hold_cnt        <= hold_cnt_d;
      hold_p2         <= hold_p2_d;
`endif
    end
  end

endmodule
